// File: rtl/saturn_bus_pkg.sv
// Shared definitions for the Saturn nibble-bus controller: command codes,
// controller state encoding and the address length in nibbles.
package saturn_bus_pkg;

  localparam int ADDR_NIBBLES = 5;

  typedef enum logic [3:0] {
    BUS_NOP       = 4'h0,
    BUS_ID        = 4'h1,
    BUS_PC_READ   = 4'h2,
    BUS_DP_READ   = 4'h3,
    BUS_PC_WRITE  = 4'h4,
    BUS_DP_WRITE  = 4'h5,
    BUS_LOAD_PC   = 4'h6,
    BUS_LOAD_DP   = 4'h7,
    BUS_CONFIGURE = 4'h8,
    BUS_RESET     = 4'h9
  } bus_cmd_e;

  typedef enum logic [1:0] {
    ST_LOAD_CMD,
    ST_ADDR,
    ST_READ_CMD,
    ST_READ
  } bus_state_e;

endpackage

// File: rtl/saturn_bus_ctrl.sv
// Saturn nibble-bus instruction fetcher: sends LOAD_PC plus the address,
// then PC_READ, then fetches one nibble per phase-0 clock-enabled cycle.
module saturn_bus_ctrl #(
  parameter int         ADDR_NIBBLES = saturn_bus_pkg::ADDR_NIBBLES,
  parameter logic [3:0] CMD_PC_READ  = saturn_bus_pkg::BUS_PC_READ,
  parameter logic [3:0] CMD_LOAD_PC  = saturn_bus_pkg::BUS_LOAD_PC
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_clk_en,
  input  logic [3:0]                i_phases,
  input  logic [31:0]               i_cycle_ctr,
  input  logic [4*ADDR_NIBBLES-1:0] i_current_pc,
  input  logic                      i_pc_reload,
  input  logic [3:0]                i_bus_data,
  output logic [3:0]                o_bus_data,
  output logic                      o_bus_cmd_data,
  output logic                      o_bus_strobe,
  output logic [3:0]                o_nibble,
  output logic                      o_nibble_valid,
  output logic                      o_bus_busy
);
  import saturn_bus_pkg::*;

  localparam logic [2:0] LAST_NIBBLE = 3'(ADDR_NIBBLES - 1);

  bus_state_e                state;
  logic [4*ADDR_NIBBLES-1:0] addr;
  logic [2:0]                ctr;
  logic                      reload_pending;

  // The cycle counter only feeds simulation tracing in the core model.
  logic unused_cycle_ctr;
  assign unused_cycle_ctr = ^i_cycle_ctr;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= ST_LOAD_CMD;
      addr           <= '0;
      ctr            <= '0;
      reload_pending <= 1'b0;
      o_bus_data     <= 4'h0;
      o_bus_cmd_data <= 1'b0;
      o_bus_strobe   <= 1'b0;
      o_nibble       <= 4'h0;
      o_nibble_valid <= 1'b0;
      o_bus_busy     <= 1'b1;
    end else begin
      // NOTE: pulses default low here and are overridden later in the same
      // block; non-blocking assignment makes the last write win cleanly.
      o_bus_strobe   <= 1'b0;
      o_nibble_valid <= 1'b0;
      if (!i_clk_en) begin
        if (i_pc_reload) reload_pending <= 1'b1;
      end else if (i_pc_reload || reload_pending) begin
        // A reload beats every state; any partially sent address is dropped.
        reload_pending <= 1'b0;
        state          <= ST_LOAD_CMD;
        o_bus_busy     <= 1'b1;
      end else begin
        unique case (state)
          ST_LOAD_CMD: begin
            o_bus_data     <= CMD_LOAD_PC;
            o_bus_cmd_data <= 1'b1;
            o_bus_strobe   <= 1'b1;
            addr           <= i_current_pc;
            ctr            <= '0;
            state          <= ST_ADDR;
          end
          ST_ADDR: begin
            o_bus_data     <= 4'(addr >> {ctr, 2'b00});
            o_bus_cmd_data <= 1'b0;
            o_bus_strobe   <= 1'b1;
            if (ctr == LAST_NIBBLE) state <= ST_READ_CMD;
            else                    ctr   <= ctr + 3'd1;
          end
          ST_READ_CMD: begin
            o_bus_data     <= CMD_PC_READ;
            o_bus_cmd_data <= 1'b1;
            o_bus_strobe   <= 1'b1;
            o_bus_busy     <= 1'b0;
            state          <= ST_READ;
          end
          ST_READ: begin
            if (i_phases[0]) begin
              o_bus_cmd_data <= 1'b0;
              o_bus_strobe   <= 1'b1;
              o_nibble       <= i_bus_data;
              o_nibble_valid <= 1'b1;
            end
          end
          default: state <= ST_LOAD_CMD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// Self-checking bench for saturn_bus_ctrl: expected bus nibbles and fetched
// instruction nibbles are queued as stimulus is driven and matched at the end.
module tb_saturn_bus_ctrl;
  import saturn_bus_pkg::*;

  typedef struct packed {
    logic       cmd;
    logic [3:0] data;
    logic       chk_data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en = 1'b0;
  logic [3:0]  phases = 4'h0;
  logic [31:0] cycle_ctr = 32'd0;
  logic [19:0] current_pc = 20'h0;
  logic        pc_reload = 1'b0;
  logic [3:0]  bus_data_in = 4'h0;
  logic [3:0]  bus_data_out;
  logic        bus_cmd_data;
  logic        bus_strobe;
  logic [3:0]  nibble;
  logic        nibble_valid;
  logic        bus_busy;

  int n_checks = 0;
  int n_pass = 0;

  txn_t       exp_bus[$];
  txn_t       obs_bus[$];
  logic [3:0] exp_nib[$];
  logic [3:0] obs_nib[$];

  saturn_bus_ctrl dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_clk_en       (clk_en),
    .i_phases       (phases),
    .i_cycle_ctr    (cycle_ctr),
    .i_current_pc   (current_pc),
    .i_pc_reload    (pc_reload),
    .i_bus_data     (bus_data_in),
    .o_bus_data     (bus_data_out),
    .o_bus_cmd_data (bus_cmd_data),
    .o_bus_strobe   (bus_strobe),
    .o_nibble       (nibble),
    .o_nibble_valid (nibble_valid),
    .o_bus_busy     (bus_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_ctr <= cycle_ctr + 32'd1;

  // Record every strobed bus nibble and every fetched nibble mid-cycle.
  always @(negedge clk) begin
    if (bus_strobe)   obs_bus.push_back('{cmd: bus_cmd_data, data: bus_data_out, chk_data: 1'b1});
    if (nibble_valid) obs_nib.push_back(nibble);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #10;
    n_checks++; if (bus_busy !== 1'b1)     $display("FAIL reset_busy: got %b want 1", bus_busy);       else n_pass++;
    n_checks++; if (bus_strobe !== 1'b0)   $display("FAIL reset_strobe: got %b want 0", bus_strobe);   else n_pass++;
    n_checks++; if (nibble_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", nibble_valid); else n_pass++;
    n_checks++; if (bus_data_out !== 4'h0) $display("FAIL reset_data: got %h want 0", bus_data_out);  else n_pass++;
    n_checks++; if (bus_cmd_data !== 1'b0) $display("FAIL reset_cmd: got %b want 0", bus_cmd_data);   else n_pass++;
    n_checks++; if (nibble !== 4'h0)       $display("FAIL reset_nibble: got %h want 0", nibble);      else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Full 7-nibble load; with gap set, every cycle is preceded by a disabled one.
  task automatic test_load_sequence(input logic [19:0] pc, input bit gap);
    current_pc = pc;
    phases     = 4'b0010;
    exp_bus.push_back('{cmd: 1'b1, data: 4'h6, chk_data: 1'b1});
    for (int i = 0; i < 5; i++) exp_bus.push_back('{cmd: 1'b0, data: pc[4*i +: 4], chk_data: 1'b1});
    exp_bus.push_back('{cmd: 1'b1, data: 4'h2, chk_data: 1'b1});
    for (int i = 0; i < 7; i++) begin
      if (gap) begin
        clk_en = 1'b0;
        tick();
        n_checks++; if (bus_strobe !== 1'b0) $display("FAIL load_gap_strobe[%0d]: got %b want 0", i, bus_strobe); else n_pass++;
      end
      clk_en = 1'b1;
      tick();
      if (i == 0) current_pc = ~pc;
      n_checks++; if (bus_strobe !== 1'b1) $display("FAIL load_strobe[%0d]: got %b want 1", i, bus_strobe); else n_pass++;
      n_checks++;
      if (bus_busy !== (i < 6)) $display("FAIL load_busy[%0d]: got %b want %b", i, bus_busy, (i < 6));
      else n_pass++;
    end
  endtask

  task automatic test_stream();
    logic [3:0] vals [3];
    vals = '{4'hA, 4'h5, 4'hC};
    clk_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 4; p++) begin
        phases      = 4'(1 << p);
        bus_data_in = (p == 0) ? vals[r] : ~vals[r];
        if (p == 0) begin
          exp_bus.push_back('{cmd: 1'b0, data: 4'h0, chk_data: 1'b0});
          exp_nib.push_back(vals[r]);
        end
        tick();
        n_checks++; if (bus_strobe !== (p == 0))   $display("FAIL stream_strobe[%0d.%0d]: got %b", r, p, bus_strobe);  else n_pass++;
        n_checks++; if (nibble_valid !== (p == 0)) $display("FAIL stream_valid[%0d.%0d]: got %b", r, p, nibble_valid); else n_pass++;
        n_checks++; if (bus_busy !== 1'b0)         $display("FAIL stream_busy[%0d.%0d]: got %b want 0", r, p, bus_busy); else n_pass++;
        n_checks++; if (nibble !== vals[r])        $display("FAIL stream_nibble[%0d.%0d]: got %h want %h", r, p, nibble, vals[r]); else n_pass++;
      end
    end
    phases = 4'h0;
    tick();
    n_checks++; if (bus_strobe !== 1'b0) $display("FAIL stream_no_phase: got %b want 0", bus_strobe); else n_pass++;
    clk_en = 1'b0;
    phases = 4'h1;
    tick();
    n_checks++; if (nibble_valid !== 1'b0) $display("FAIL stream_clk_en_low: got %b want 0", nibble_valid); else n_pass++;
    phases = 4'h0;
  endtask

  task automatic test_reload_mid_addr();
    clk_en     = 1'b1;
    current_pc = 20'h12345;
    pc_reload  = 1'b1;
    tick();
    pc_reload = 1'b0;
    n_checks++; if (bus_strobe !== 1'b0) $display("FAIL reload_strobe: got %b want 0", bus_strobe); else n_pass++;
    n_checks++; if (bus_busy !== 1'b1)   $display("FAIL reload_busy: got %b want 1", bus_busy);     else n_pass++;
    exp_bus.push_back('{cmd: 1'b1, data: 4'h6, chk_data: 1'b1});
    exp_bus.push_back('{cmd: 1'b0, data: 4'h5, chk_data: 1'b1});
    exp_bus.push_back('{cmd: 1'b0, data: 4'h4, chk_data: 1'b1});
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus_busy !== 1'b1) $display("FAIL partial_busy[%0d]: got %b want 1", i, bus_busy); else n_pass++;
    end
    current_pc = 20'hABCDE;
    pc_reload  = 1'b1;
    tick();
    pc_reload = 1'b0;
    n_checks++; if (bus_strobe !== 1'b0) $display("FAIL mid_reload_strobe: got %b want 0", bus_strobe); else n_pass++;
    n_checks++; if (bus_busy !== 1'b1)   $display("FAIL mid_reload_busy: got %b want 1", bus_busy);     else n_pass++;
    test_load_sequence(20'hABCDE, 1'b0);
  endtask

  task automatic test_reload_no_clk_en();
    clk_en    = 1'b0;
    pc_reload = 1'b1;
    tick();
    pc_reload = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus_busy !== 1'b0) $display("FAIL pending_hold_busy[%0d]: got %b want 0", i, bus_busy); else n_pass++;
      tick();
    end
    clk_en      = 1'b1;
    phases      = 4'h1;
    bus_data_in = 4'h7;
    tick();
    n_checks++; if (bus_strobe !== 1'b0)   $display("FAIL pending_strobe: got %b want 0", bus_strobe);  else n_pass++;
    n_checks++; if (nibble_valid !== 1'b0) $display("FAIL pending_valid: got %b want 0", nibble_valid); else n_pass++;
    n_checks++; if (bus_busy !== 1'b1)     $display("FAIL pending_busy: got %b want 1", bus_busy);      else n_pass++;
    test_load_sequence(20'h5A5A5, 1'b1);
  endtask

  task automatic test_async_reset();
    clk_en     = 1'b1;
    current_pc = 20'h0F0F0;
    exp_bus.push_back('{cmd: 1'b1, data: 4'h6, chk_data: 1'b1});
    exp_bus.push_back('{cmd: 1'b0, data: 4'h0, chk_data: 1'b1});
    exp_bus.push_back('{cmd: 1'b0, data: 4'hF, chk_data: 1'b1});
    pc_reload = 1'b1;
    tick();
    pc_reload = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_checks++; if (bus_busy !== 1'b1)     $display("FAIL async_busy: got %b want 1", bus_busy);      else n_pass++;
    n_checks++; if (bus_data_out !== 4'h0) $display("FAIL async_data: got %h want 0", bus_data_out); else n_pass++;
    n_checks++; if (bus_cmd_data !== 1'b0) $display("FAIL async_cmd: got %b want 0", bus_cmd_data);  else n_pass++;
    n_checks++; if (nibble !== 4'h0)       $display("FAIL async_nibble: got %h want 0", nibble);     else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    test_load_sequence(20'h9E3C1, 1'b0);
  endtask

  task automatic test_bus_stream();
    txn_t       e, o;
    logic [3:0] en, on;
    @(negedge clk);
    #1;
    n_checks++;
    if (obs_bus.size() != exp_bus.size())
      $display("FAIL bus_count: got %0d want %0d", obs_bus.size(), exp_bus.size());
    else n_pass++;
    n_checks++;
    if (obs_nib.size() != exp_nib.size())
      $display("FAIL nibble_count: got %0d want %0d", obs_nib.size(), exp_nib.size());
    else n_pass++;
    for (int i = 0; exp_bus.size() > 0 && obs_bus.size() > 0; i++) begin
      e = exp_bus.pop_front();
      o = obs_bus.pop_front();
      n_checks++;
      if (o.cmd !== e.cmd || (e.chk_data && o.data !== e.data))
        $display("FAIL bus_txn[%0d]: got cmd=%b data=%h want cmd=%b data=%h", i, o.cmd, o.data, e.cmd, e.data);
      else n_pass++;
    end
    for (int i = 0; exp_nib.size() > 0 && obs_nib.size() > 0; i++) begin
      en = exp_nib.pop_front();
      on = obs_nib.pop_front();
      n_checks++; if (on !== en) $display("FAIL fetched_nibble[%0d]: got %h want %h", i, on, en); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_load_sequence(20'h00000, 1'b0);
    test_stream();
    test_reload_mid_addr();
    test_reload_no_clk_en();
    test_stream();
    test_async_reset();
    test_bus_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
